// File: rtl/rx_fifo.sv
// Router receive-path flit buffer: write/full in, read/empty out, occupancy and sticky error flags.
// Define RX_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.

`ifndef SIZE
`define SIZE 8
`endif

module rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_write,
  input  logic [`SIZE-1:0]      fifo_data_in,
  output logic                  fifo_full,
  input  logic                  fifo_read,
  output logic                  fifo_empty,
  output logic [`SIZE-1:0]      fifo_data_out,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int unsigned DW    = `SIZE;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
  logic          push;
  logic          pop;

  // Status is decoded from the count register only, never from the request inputs.
  assign fifo_full      = (count == CW'(DEPTH));
  assign fifo_empty     = (count == '0);
  assign fifo_count     = count;
  assign fifo_overflow  = overflow;
  assign fifo_underflow = underflow;

  assign push = fifo_write && !fifo_full;
  assign pop  = fifo_read  && !fifo_empty;

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky debug flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo_write && fifo_full) begin
        overflow <= 1'b1;
      end
      if (fifo_read && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef RX_FIFO_FWFT_EN
  assign fifo_data_out = fifo_empty ? '0 : mem[rd_ptr];
`else
  logic [DW-1:0] data_q;

  // Popped flit is captured at the pop edge and held until the next accepted pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (pop) begin
      data_q <= mem[rd_ptr];
    end
  end

  assign fifo_data_out = data_q;
`endif

endmodule
